// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/load-use hazard unit: outputs are combinational from the slot state, and issue reaches slot 0 one clk later.
// stall_ext freezes every slot. Optional counters are enabled with FWD_PERF_CNT_EN.
module fwd_scoreboard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int AW         = 5,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_ext,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  input  logic                    issue_regwrite,
  input  logic                    issue_is_load,
  input  logic [NUM_SRC*AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [NUM_SRC*AW-1:0]   ex_rs,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    hazard_stall,
  output logic [(DEPTH+1)*AW-1:0] slot_rd_dbg
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_fwd_cnt
`endif
);

  logic [DEPTH:0][AW-1:0] rd_q, rd_d;
  logic [DEPTH:0]         wr_q, wr_d;
  logic [DEPTH:0]         ld_q, ld_d;
  logic [DEPTH:0]         vld;
  logic [NUM_SRC*SELW-1:0] sel_raw;
  logic                   hz_raw;
  logic                   illegal_fwd;

  // x0 is never a forwarding or hazard source
  always_comb begin
    vld = '0;
    for (int k = 0; k <= DEPTH; k++) begin
      vld[k] = wr_q[k] && (rd_q[k] != '0);
    end
  end

  always_comb begin
    int hit;
    sel_raw     = '0;
    illegal_fwd = 1'b0;
    hit         = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit = 0;
      // scan oldest to youngest so the youngest writer overrides
      for (int k = DEPTH; k >= 1; k--) begin
        if (vld[k] && rd_q[k] == ex_rs[i*AW +: AW]) hit = k;
      end
      sel_raw[i*SELW +: SELW] = SELW'(hit);
      if (hit != 0 && ld_q[hit] && hit < LOAD_STAGE) illegal_fwd = 1'b1;
    end
  end

  always_comb begin
    hz_raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < LOAD_STAGE - 1; j++) begin
        if (id_rs_used[i] && vld[j] && ld_q[j] && rd_q[j] == id_rs[i*AW +: AW]) hz_raw = 1'b1;
      end
    end
  end

  assign fwd_sel      = reset ? '0 : sel_raw;
  assign hazard_stall = !reset && hz_raw;
  assign slot_rd_dbg  = rd_q;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    ld_d = ld_q;
    if (!stall_ext) begin
      for (int k = 1; k <= DEPTH; k++) begin
        rd_d[k] = rd_q[k-1];
        wr_d[k] = wr_q[k-1];
        ld_d[k] = ld_q[k-1];
      end
      if (issue_valid && !hazard_stall && !flush) begin
        rd_d[0] = issue_rd;
        wr_d[0] = issue_regwrite;
        ld_d[0] = issue_is_load;
      end else begin
        rd_d[0] = '0;
        wr_d[0] = 1'b0;
        ld_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      ld_q <= ld_d;
    end
  end

  // load data is not available before LOAD_STAGE, so selecting it would be a pipeline bug
  always_ff @(posedge clk) begin
    if (!reset) assert (!illegal_fwd);
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!stall_ext) begin
      if (hazard_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (fwd_sel != '0 && fwd_cnt_q != '1)  fwd_cnt_d   = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
